// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment display driver.
//
// Selects one of SOURCES digit sets and scans its DIGITS digits onto a shared
// segment bus with one-hot digit enables. The source changes only at a frame
// boundary, so a single frame never mixes two sources. Segment data and the
// blank mask are sampled live every cycle.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   src_seg     SOURCES*DIGITS 7-bit patterns; digit d of source s at
//               [(s*DIGITS+d)*7 +: 7], digit 0 is the rightmost
//   src_sel     requested source, values >= SOURCES ignored
//   blank       per-digit blank mask, 1 = digit dark
//   seg_out     registered segment pattern of the driven digit
//   dig_en      registered one-hot digit enable, active-high
//   frame_start one-cycle pulse for the first slot cycle of each frame
//   active_src  source currently displayed
module seg_scan_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SOURCES  = 2,
  parameter int unsigned PRESCALE = 50000,
  localparam int unsigned SEL_W   = $clog2(SOURCES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SOURCES*DIGITS*7-1:0]  src_seg,
  input  logic [SEL_W-1:0]             src_sel,
  input  logic [DIGITS-1:0]            blank,
  output logic [6:0]                   seg_out,
  output logic [DIGITS-1:0]            dig_en,
  output logic                         frame_start,
  output logic [SEL_W-1:0]             active_src
);

  localparam int unsigned DigW = $clog2(DIGITS);
  localparam int unsigned CntW = $clog2(PRESCALE);

  // Scan pointer and selected source.
  logic [DigW-1:0]   dig_q, dig_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]  active_src_q, active_src_d;

  // Registered outputs.
  logic [6:0]        seg_out_q, seg_out_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;
  logic              frame_start_q, frame_start_d;

  logic cnt_last, dig_last, frame_end;
  logic [6:0] seg_sel;
  logic       blank_sel;

  // Pointer advance and frame-synchronous source load.
  always_comb begin
    cnt_last     = (cnt_q == CntW'(PRESCALE - 1));
    dig_last     = (dig_q == DigW'(DIGITS - 1));
    frame_end    = cnt_last && dig_last;
    cnt_d        = cnt_last ? '0 : cnt_q + 1'b1;
    dig_d        = dig_q;
    if (cnt_last) begin
      dig_d = dig_last ? '0 : dig_q + 1'b1;
    end
    active_src_d = active_src_q;
    if (frame_end && (32'(src_sel) < SOURCES)) begin
      active_src_d = src_sel;
    end
  end

  // Select the current digit's pattern and blank bit from the live inputs.
  always_comb begin
    seg_sel   = '0;
    blank_sel = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (dig_q == DigW'(d)) begin
        blank_sel = blank[d];
        for (int s = 0; s < int'(SOURCES); s++) begin
          if (active_src_q == SEL_W'(s)) begin
            seg_sel = src_seg[(s*int'(DIGITS)+d)*7 +: 7];
          end
        end
      end
    end
  end

  // Output next-state: cnt == 0 is the dead cycle with every digit off.
  always_comb begin
    seg_out_d     = blank_sel ? 7'b0 : seg_sel;
    dig_en_d      = '0;
    if ((cnt_q != '0) && !blank_sel) begin
      dig_en_d = DIGITS'(1) << dig_q;
    end
    frame_start_d = (cnt_q == '0) && (dig_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q         <= '0;
      cnt_q         <= '0;
      active_src_q  <= '0;
      seg_out_q     <= '0;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      dig_q         <= dig_d;
      cnt_q         <= cnt_d;
      active_src_q  <= active_src_d;
      seg_out_q     <= seg_out_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_out     = seg_out_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;
  assign active_src  = active_src_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed testbench for seg_scan_mux with DIGITS=4, SOURCES=3, PRESCALE=4.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_seg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [83:0] src_seg;
  logic [1:0]  src_sel;
  logic [3:0]  blank;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        frame_start;
  logic [1:0]  active_src;

  seg_scan_mux #(
    .DIGITS  (4),
    .SOURCES (3),
    .PRESCALE(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_seg    (src_seg),
    .src_sel    (src_sel),
    .blank      (blank),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .frame_start(frame_start),
    .active_src (active_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;
  int ph       = 0;  // frame position (dig*4+cnt) that produced current outputs

  logic [6:0] pat [3][4];
  // Expected dig_en per frame position, unblanked and with blank = 4'b0100.
  logic [3:0] den_tbl [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                               4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
  logic [3:0] blk_tbl [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s at t=%0t ph=%0d: got %0h expected %0h", tag, $time, ph, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic load_src();
    for (int s = 0; s < 3; s++) begin
      for (int d = 0; d < 4; d++) begin
        src_seg[(s*4+d)*7 +: 7] = pat[s][d];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    edges++;
    ph = (edges - 1) % 16;
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ph != target && n < 40);
  endtask

  initial begin
    pat[0] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    pat[1] = '{7'h66, 7'h6D, 7'h7D, 7'h07};
    pat[2] = '{7'h7F, 7'h6F, 7'h77, 7'h7C};
    src_seg = '0;
    load_src();
    src_sel = 2'd0;
    blank   = 4'b0000;
    rst_n   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_out), 32'h0);
    check("rst_den", 32'(dig_en), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_src", 32'(active_src), 32'h0);

    // Scan sequence from release.
    rst_n = 1'b1;
    edges = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("scan_den", 32'(dig_en), 32'(den_tbl[ph]));
      check("scan_fs", 32'(frame_start), (ph == 0) ? 32'h1 : 32'h0);
      check("scan_seg", 32'(seg_out), 32'(pat[0][ph/4]));
    end

    // Frame-synchronous switch requested during digit 1.
    run_until(5);
    src_sel = 2'd1;
    while (ph != 15) begin
      step();
      check("sw_seg_old", 32'(seg_out), 32'(pat[0][ph/4]));
      check("sw_src", 32'(active_src), (ph == 15) ? 32'h1 : 32'h0);
    end
    step();
    check("sw_fs", 32'(frame_start), 32'h1);
    check("sw_seg_new", 32'(seg_out), 32'h66);
    check("sw_src_new", 32'(active_src), 32'h1);

    // Invalid select held across a boundary.
    src_sel = 2'd3;
    repeat (16) begin
      step();
      check("inv_seg", 32'(seg_out), 32'(pat[1][ph/4]));
      check("inv_src", 32'(active_src), 32'h1);
    end
    check("inv_fs", 32'(frame_start), 32'h1);

    // Move to source 2.
    src_sel = 2'd2;
    repeat (16) step();
    check("src2_seg", 32'(seg_out), 32'h7F);
    check("src2_src", 32'(active_src), 32'h2);

    // Blank digit 2.
    blank = 4'b0100;
    repeat (15) begin
      step();
      check("blk_den", 32'(dig_en), 32'(blk_tbl[ph]));
      check("blk_seg", 32'(seg_out), (ph / 4 == 2) ? 32'h0 : 32'(pat[2][ph/4]));
    end
    blank = 4'b0000;

    // Asynchronous reset in the middle of digit 2.
    run_until(9);
    check("pre_rst_den", 32'(dig_en), 32'h4);
    check("pre_rst_seg", 32'(seg_out), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg_out), 32'h0);
    check("arst_den", 32'(dig_en), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);
    check("arst_src", 32'(active_src), 32'h0);
    src_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    step();
    check("restart_fs", 32'(frame_start), 32'h1);
    check("restart_den", 32'(dig_en), 32'h0);
    check("restart_seg", 32'(seg_out), 32'h3F);
    check("restart_src", 32'(active_src), 32'h0);

    // Live data change mid-slot.
    run_until(5);
    check("live_before", 32'(seg_out), 32'h06);
    pat[0][1] = 7'h5B;
    load_src();
    step();
    check("live_after", 32'(seg_out), 32'h5B);
    step();
    check("live_hold", 32'(seg_out), 32'h5B);
    check("live_den", 32'(dig_en), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised, time-multiplexed seven-segment display driver. It selects one of `SOURCES` digit sets (for example decimal, octal or hex renderings of the same value) and scans the digits of that set onto a single shared segment bus with one-hot digit enables. Source switching is frame-synchronous, so a displayed frame never mixes two sources. It sits between the per-radix seven-segment encoders and the board's multiplexed display pins.

## Interface
Parameters:
- `DIGITS`, 4, number of display digits (≥2).
- `SOURCES`, 2, number of selectable digit sets (≥2).
- `PRESCALE`, 50000, clock cycles per digit slot (≥2).
- `SEL_W` (localparam), `$clog2(SOURCES)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `src_seg`  in  `SOURCES*DIGITS*7`  segment patterns. Digit d of source s is at bits `[(s*DIGITS+d)*7 +: 7]`. Digit 0 is the rightmost digit.
- `src_sel`  in  `SEL_W`  requested source. Values ≥ `SOURCES` are ignored.
- `blank`  in  `DIGITS`  per-digit blank mask, 1 = digit dark.
- `seg_out`  out  7  segment pattern of the digit currently driven. Bit encoding is passed through unchanged from `src_seg`.
- `dig_en`  out  `DIGITS`  one-hot digit enable, active-high. All zeros when no digit is lit.
- `frame_start`  out  1  one-cycle pulse at the start of each frame.
- `active_src`  out  `SEL_W`  source currently displayed.

## Operation
- **Scan pointer** is the pair (`dig`, `cnt`).
  - `cnt` counts 0..`PRESCALE-1`.
  - When `cnt` = `PRESCALE-1`, `cnt` returns to 0 and `dig` advances to (`dig`+1) mod `DIGITS`.
  - One frame = `DIGITS*PRESCALE` cycles.
- **Frame boundary** is the edge where the pointer moves from (`DIGITS-1`, `PRESCALE-1`) to (0, 0).
  - On that edge `active_src` loads `src_sel` if `src_sel` < `SOURCES`; otherwise it holds its value.
  - `src_sel` is ignored on every other edge.
- **Outputs** are registered every cycle from the current pointer:
  - `seg_out` ← `src_seg[active_src][dig]`, or 7'b0 when `blank[dig]` = 1.
  - `dig_en` ← one-hot(`dig`) only if `cnt` ≠ 0 and `blank[dig]` = 0; otherwise all zeros. The `cnt` = 0 cycle is a dead cycle (anti-ghosting: segments settle while all digits are off).
  - `frame_start` ← 1 when pointer = (0, 0), else 0.
- **Live data:** `src_seg` and `blank` are sampled every cycle. Changes mid-slot take effect one cycle later. There is no frame latching for data, only for source selection.
- **Reset** (`rst_n` low):
  - Pointer (0, 0), `active_src` = 0, `seg_out` = 0, `dig_en` = 0, `frame_start` = 0.
  - Takes effect immediately and asynchronously, including mid-frame.
- **Restart after reset:** the scan resumes at digit 0, cycle 0, with source 0.

## Timing
- Output latency: 1 cycle from pointer state to outputs.
- First edge after `rst_n` rises: `frame_start` = 1, `dig_en` = 0, `seg_out` = digit 0 of source 0.
- Each digit slot: `dig_en` is low for 1 cycle, then high for `PRESCALE-1` cycles.
- `active_src` changes on the same edge the pointer enters (0, 0). Outputs reflect the new source from the next edge, which is the `frame_start` cycle.
- Selection latency: worst case `DIGITS*PRESCALE` cycles after `src_sel` changes.
- Holding `src_sel` constant across the boundary edge guarantees the switch. A value applied only between boundaries is never taken.
- `frame_start` period is exactly `DIGITS*PRESCALE` cycles, with no drift.

## Test plan
All scenarios use `DIGITS`=4, `SOURCES`=3, `PRESCALE`=4, frame = 16 cycles.

1. **Reset and scan sequence.** Hold `rst_n`=0, then release.
   - While low: all outputs 0.
   - After release: `frame_start` on the first edge. `dig_en` sequence 0000, 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3, repeating every 16 cycles.
2. **Frame-synchronous switch.** Set `src_sel`=1 during the digit 1 slot.
   - `seg_out` keeps showing source 0 digits through digit 3.
   - `active_src`=1 at the boundary; the `frame_start` cycle shows source 1, digit 0.
3. **Invalid select.** Set `src_sel`=3 (≥`SOURCES`) across a boundary → `active_src` holds its previous value and no glitch appears on `seg_out`.
4. **Blanking.** Set `blank`=4'b0100 → during the digit 2 slot `dig_en`=0000 and `seg_out`=0; other digits are unaffected.
5. **Mid-frame reset.** Pull `rst_n` low during the digit 2 slot with `active_src`=2.
   - Outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the scan restarts at digit 0 with `active_src`=0.
6. **Live data.** Change the source 0, digit 1 pattern from 7'h06 to 7'h5B at slot cycle 2 → `seg_out` shows 7'h5B one cycle later, within the same slot.
